// File: rtl/ser_to_par_pkg.sv
// Shared TMDS definitions: control-token codes (also used by the serializer)
// and the word-alignment FSM state encoding.
package ser_to_par_pkg;

  localparam int WORD_W = 10;
  localparam int HIST_W = 2 * WORD_W;

  localparam logic [WORD_W-1:0] TOK_CTRL0 = 10'h354;
  localparam logic [WORD_W-1:0] TOK_CTRL1 = 10'h0AB;
  localparam logic [WORD_W-1:0] TOK_CTRL2 = 10'h154;
  localparam logic [WORD_W-1:0] TOK_CTRL3 = 10'h2AB;

  localparam logic [2:0] PHASE_LAST = 3'd4;
  localparam logic [3:0] SLIP_LAST  = 4'd9;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/tmds_token_det.sv
// Flags a 10-bit TMDS word that is one of the four control-period tokens.
module tmds_token_det
  import ser_to_par_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              is_token
);

  always_comb begin
    is_token = (word == TOK_CTRL0) || (word == TOK_CTRL1) ||
               (word == TOK_CTRL2) || (word == TOK_CTRL3);
  end

endmodule

// File: rtl/ser_to_par.sv
// 2-bit-per-cycle deserializer for one TMDS lane: 20-bit history, bit-slip
// window into 10-bit words, and a token-based SEARCH/SETTLE/LOCKED aligner.
module ser_to_par
  import ser_to_par_pkg::*;
#(
  parameter int LOCK_CNT      = 8,
  parameter int TIMEOUT_WORDS = 1024,
  parameter int LOSS_WORDS    = 4096
) (
  input  logic        clk_5x,
  input  logic        sys_rst_n,
  input  logic        ser_rise,
  input  logic        ser_fall,
  output logic [9:0]  par_data,
  output logic        par_valid,
  output logic        locked,
  output logic [3:0]  slip
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_WORDS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);

  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [TW-1:0] TMO_TGT  = TW'(TIMEOUT_WORDS);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_WORDS);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] par_data_q, par_data_d;
  logic              par_valid_q, par_valid_d;
  logic [3:0]        slip_q, slip_d;
  align_state_e      state_q, state_d;
  logic [MW-1:0]     match_q, match_d, match_inc;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [LW-1:0]     loss_q, loss_d, loss_inc;
  logic              settle_q, settle_d;

  logic [HIST_W-1:0] hist_shift;
  logic              is_token;

  // Newest pair enters at the top, so hist_q[0] is always the oldest bit.
  always_comb begin
    hist_d      = {ser_fall, ser_rise, hist_q[HIST_W-1:2]};
    cnt_d       = (cnt_q == PHASE_LAST) ? 3'd0 : cnt_q + 3'd1;
    hist_shift  = hist_q >> slip_q;
    par_valid_d = (cnt_q == PHASE_LAST);
    par_data_d  = (cnt_q == PHASE_LAST) ? hist_shift[WORD_W-1:0] : par_data_q;
  end

  tmds_token_det u_tok (
    .word     (par_data_q),
    .is_token (is_token)
  );

  // The aligner judges each word on the cycle its par_valid strobe is high.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    tmo_d     = tmo_q;
    loss_d    = loss_q;
    settle_d  = settle_q;
    slip_d    = slip_q;
    match_inc = is_token ? match_q + 1'b1 : '0;
    tmo_inc   = tmo_q + 1'b1;
    loss_inc  = loss_q + 1'b1;

    if (par_valid_q) begin
      case (state_q)
        SEARCH: begin
          match_d = match_inc;
          tmo_d   = tmo_inc;
          if (match_inc == LOCK_TGT) begin
            // Lock takes priority over a timeout on the same word.
            state_d = LOCKED;
            match_d = '0;
            tmo_d   = '0;
            loss_d  = '0;
          end else if (tmo_inc == TMO_TGT) begin
            slip_d   = (slip_q == SLIP_LAST) ? 4'd0 : slip_q + 4'd1;
            match_d  = '0;
            tmo_d    = '0;
            settle_d = 1'b0;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q) begin
            settle_d = 1'b0;
            state_d  = SEARCH;
          end else begin
            settle_d = 1'b1;
          end
        end
        LOCKED: begin
          if (is_token) begin
            loss_d = '0;
          end else if (loss_inc == LOSS_TGT) begin
            state_d = SEARCH;
            loss_d  = '0;
            match_d = '0;
            tmo_d   = '0;
          end else begin
            loss_d = loss_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_5x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist_q      <= '0;
      cnt_q       <= '0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      slip_q      <= '0;
      state_q     <= SEARCH;
      match_q     <= '0;
      tmo_q       <= '0;
      loss_q      <= '0;
      settle_q    <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      slip_q      <= slip_d;
      state_q     <= state_d;
      match_q     <= match_d;
      tmo_q       <= tmo_d;
      loss_q      <= loss_d;
      settle_q    <= settle_d;
    end
  end

  assign par_data  = par_data_q;
  assign par_valid = par_valid_q;
  assign locked    = (state_q == LOCKED);
  assign slip      = slip_q;

endmodule

// File: tb/tb_ser_to_par.sv
// Directed bench for ser_to_par with shortened timeout/loss windows so that
// every alignment scenario completes in a few thousand cycles.
module tb_ser_to_par;

  localparam int LOCK_N = 8;
  localparam int TMO_N  = 16;
  localparam int LOSS_N = 32;

  logic       clk_5x = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       ser_rise = 1'b0;
  logic       ser_fall = 1'b0;
  logic [9:0] par_data;
  logic       par_valid;
  logic       locked;
  logic [3:0] slip;

  ser_to_par #(
    .LOCK_CNT      (LOCK_N),
    .TIMEOUT_WORDS (TMO_N),
    .LOSS_WORDS    (LOSS_N)
  ) dut (
    .clk_5x    (clk_5x),
    .sys_rst_n (sys_rst_n),
    .ser_rise  (ser_rise),
    .ser_fall  (ser_fall),
    .par_data  (par_data),
    .par_valid (par_valid),
    .locked    (locked),
    .slip      (slip)
  );

  always #5 clk_5x = ~clk_5x;

  int         n_chk = 0;
  int         n_err = 0;
  int         t = 0;
  int         bp = 0;
  int         dly = 0;
  int         sw_after = 0;
  bit         rnd_mode = 1'b1;
  logic [9:0] cur_word = 10'h000;
  logic [9:0] alt_word = 10'h000;

  typedef struct {
    logic [9:0] tx;
    logic [9:0] tx2;
    int         sw;
    int         dl;
    int         tk;
    logic       ev;
    logic       el;
    logic [3:0] es;
    bit         cd;
    logic [9:0] ed;
  } vec_t;

  vec_t vecs[$];

  // Word bit 0 lines up with capture window offset 0 when dly == 0.
  function automatic logic sbit(input int p);
    int idx;
    idx = (p + 12 - dly) % 10;
    return cur_word[idx];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  task automatic tick();
    if (sw_after > 0 && t == sw_after) cur_word = alt_word;
    if (rnd_mode) begin
      ser_rise = 1'($urandom_range(0, 1));
      ser_fall = 1'($urandom_range(0, 1));
    end else begin
      ser_rise = sbit(bp);
      ser_fall = sbit(bp + 1);
      bp += 2;
    end
    @(posedge clk_5x);
    #1;
    t++;
  endtask

  task automatic do_reset(input bit check_hold);
    sys_rst_n = 1'b0;
    rnd_mode  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (check_hold) begin
        chk("rst_data",  16'(par_data), 16'h0);
        chk("rst_valid", 16'(par_valid), 16'h0);
        chk("rst_locked", 16'(locked), 16'h0);
        chk("rst_slip",  16'(slip), 16'h0);
      end
    end
    sys_rst_n = 1'b1;
    rnd_mode  = 1'b0;
    t  = 0;
    bp = 0;
  endtask

  task automatic run_to(input int n);
    while (t < n) tick();
  endtask

  task automatic add(input logic [9:0] tx, input logic [9:0] tx2, input int sw,
                     input int dl, input int tk, input logic ev, input logic el,
                     input logic [3:0] es, input bit cd, input logic [9:0] ed);
    vec_t v;
    v.tx = tx; v.tx2 = tx2; v.sw = sw; v.dl = dl; v.tk = tk;
    v.ev = ev; v.el = el; v.es = es; v.cd = cd; v.ed = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int tc;
    int tr;
    bit first;
    vec_t pv;

    // Checkpoints from reset: {tx, tx2, switch_after, delay, tick, valid, locked, slip, check_data, data}
    add(10'h354, 10'h000, 0, 0,   5, 1'b1, 1'b0, 4'd0, 1'b1, 10'h000);
    add(10'h354, 10'h000, 0, 0,   7, 1'b0, 1'b0, 4'd0, 1'b1, 10'h000);
    add(10'h354, 10'h000, 0, 0,  10, 1'b1, 1'b0, 4'd0, 1'b1, 10'h354);
    add(10'h354, 10'h000, 0, 0,  45, 1'b1, 1'b0, 4'd0, 1'b1, 10'h354);
    add(10'h354, 10'h000, 0, 0,  46, 1'b0, 1'b1, 4'd0, 1'b1, 10'h354);
    add(10'h354, 10'h000, 0, 3,  80, 1'b1, 1'b0, 4'd0, 1'b1, 10'h2A6);
    add(10'h354, 10'h000, 0, 3,  81, 1'b0, 1'b0, 4'd1, 1'b0, 10'h000);
    add(10'h354, 10'h000, 0, 3,  85, 1'b1, 1'b0, 4'd1, 1'b1, 10'h153);
    add(10'h354, 10'h000, 0, 3, 170, 1'b1, 1'b0, 4'd1, 1'b0, 10'h000);
    add(10'h354, 10'h000, 0, 3, 171, 1'b0, 1'b0, 4'd2, 1'b0, 10'h000);
    add(10'h354, 10'h000, 0, 3, 261, 1'b0, 1'b0, 4'd3, 1'b0, 10'h000);
    add(10'h354, 10'h000, 0, 3, 265, 1'b1, 1'b0, 4'd3, 1'b1, 10'h354);
    add(10'h354, 10'h000, 0, 3, 310, 1'b1, 1'b0, 4'd3, 1'b1, 10'h354);
    add(10'h354, 10'h000, 0, 3, 311, 1'b0, 1'b1, 4'd3, 1'b1, 10'h354);
    add(10'h1F0, 10'h000, 0, 0,  81, 1'b0, 1'b0, 4'd1, 1'b0, 10'h000);
    add(10'h1F0, 10'h000, 0, 0, 441, 1'b0, 1'b0, 4'd5, 1'b0, 10'h000);
    add(10'h1F0, 10'h000, 0, 0, 801, 1'b0, 1'b0, 4'd9, 1'b0, 10'h000);
    add(10'h1F0, 10'h000, 0, 0, 890, 1'b1, 1'b0, 4'd9, 1'b0, 10'h000);
    add(10'h1F0, 10'h000, 0, 0, 891, 1'b0, 1'b0, 4'd0, 1'b0, 10'h000);
    add(10'h1F0, 10'h354, 34, 0, 40, 1'b1, 1'b0, 4'd0, 1'b1, 10'h1F0);
    add(10'h1F0, 10'h354, 34, 0, 45, 1'b1, 1'b0, 4'd0, 1'b1, 10'h354);
    add(10'h1F0, 10'h354, 34, 0, 80, 1'b1, 1'b0, 4'd0, 1'b0, 10'h000);
    add(10'h1F0, 10'h354, 34, 0, 81, 1'b0, 1'b1, 4'd0, 1'b1, 10'h354);

    // Reset hold with random line activity, then strobe cadence.
    cur_word = 10'h354; dly = 0; sw_after = 0;
    do_reset(1'b1);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("valid_cadence", 16'(par_valid), 16'((t % 5) == 0));
    end

    first = 1'b1;
    foreach (vecs[i]) begin
      if (first || vecs[i].tk <= t || vecs[i].tx != pv.tx || vecs[i].tx2 != pv.tx2 ||
          vecs[i].sw != pv.sw || vecs[i].dl != pv.dl) begin
        cur_word = vecs[i].tx; alt_word = vecs[i].tx2;
        sw_after = vecs[i].sw; dly = vecs[i].dl;
        do_reset(1'b0);
      end
      first = 1'b0;
      pv = vecs[i];
      run_to(vecs[i].tk);
      chk($sformatf("vec%0d_valid", i), 16'(par_valid), 16'(vecs[i].ev));
      chk($sformatf("vec%0d_locked", i), 16'(locked), 16'(vecs[i].el));
      chk($sformatf("vec%0d_slip", i), 16'(slip), 16'(vecs[i].es));
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), 16'(par_data), 16'(vecs[i].ed));
    end

    // Loss of lock after LOSS_N bad words, then re-lock on tokens.
    cur_word = 10'h354; dly = 0; sw_after = 0;
    do_reset(1'b0);
    run_to(46);
    chk("loss_pre_locked", 16'(locked), 16'h1);
    while (t % 5 != 4) tick();
    cur_word = 10'h1F0;
    tc = t;
    run_to(tc + 11);
    chk("loss_data", 16'(par_data), 16'h1F0);
    run_to(tc + 166);
    chk("loss_hold", 16'(locked), 16'h1);
    tick();
    chk("loss_drop", 16'(locked), 16'h0);
    chk("loss_slip", 16'(slip), 16'h0);
    while (t % 5 != 4) tick();
    cur_word = 10'h354;
    tr = t;
    run_to(tr + 46);
    chk("relock_pre", 16'(locked), 16'h0);
    tick();
    chk("relock", 16'(locked), 16'h1);
    chk("relock_slip", 16'(slip), 16'h0);
    chk("relock_data", 16'(par_data), 16'h354);

    // Asynchronous reset in SEARCH at slip 5.
    cur_word = 10'h1F0; dly = 0; sw_after = 0;
    do_reset(1'b0);
    run_to(443);
    chk("mid_slip5", 16'(slip), 16'h5);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_slip", 16'(slip), 16'h0);
    chk("arst_locked", 16'(locked), 16'h0);
    chk("arst_valid", 16'(par_valid), 16'h0);
    chk("arst_data", 16'(par_data), 16'h0);
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("post_rst_valid", 16'(par_valid), 16'(i == 5));
    end
    run_to(80);
    chk("post_rst_slip0", 16'(slip), 16'h0);
    tick();
    chk("post_rst_slip1", 16'(slip), 16'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ser_to_par.md
SER_TO_PAR -- requirements
Module: ser_to_par

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive control-token words required to declare lock.
REQ-002 Parameter TIMEOUT_WORDS, default 1024: words spent in SEARCH without lock before one bit-slip.
REQ-003 Parameter LOSS_WORDS, default 4096: words without any control token in LOCKED before lock is dropped.
REQ-004 clk_5x  input  1  bit clock, 5x pixel clock; one clock only; DDR input capture is external, two bits delivered per clk_5x cycle.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ser_rise  input  1  earlier serial bit of the current clk_5x cycle.
REQ-007 ser_fall  input  1  later serial bit of the current clk_5x cycle.
REQ-008 par_data  output  10  aligned TMDS word; bit 0 is the first bit received.
REQ-009 par_valid  output  1  one-cycle strobe; par_data is new.
REQ-010 locked  output  1  word alignment achieved.
REQ-011 slip  output  4  current bit offset, 0..9.

Function
REQ-012 The block SHALL shift a 20-bit history register each cycle: hist <= {ser_fall, ser_rise, hist[19:2]}; hist[0] is the oldest bit.
REQ-013 The block SHALL run a phase counter cnt 0..4 (wrap 4->0), free-running from reset.
REQ-014 On the edge where cnt==4, the block SHALL register par_data <= hist[slip+9:slip] and pulse par_valid high for exactly one cycle; period exactly 5 cycles; no other gaps.
REQ-015 A word is a control token iff it equals 10'h354, 10'h0AB, 10'h154 or 10'h2AB.
REQ-016 The FSM SHALL have states SEARCH, SETTLE, LOCKED; reset state SEARCH.
REQ-017 SEARCH: each valid token word increments match_cnt; each valid non-token word clears it; each valid word increments tmo_cnt.
REQ-018 SEARCH: match_cnt reaching LOCK_CNT SHALL move to LOCKED, assert locked on the next cycle, and clear counters.
REQ-019 SEARCH: tmo_cnt reaching TIMEOUT_WORDS without lock SHALL increment slip (9 wraps to 0), clear match_cnt and tmo_cnt, go to SETTLE.
REQ-020 Simultaneous lock and timeout on the same word: lock wins; slip unchanged.
REQ-021 SETTLE: the next 2 valid words SHALL be ignored by the counters, then return to SEARCH; par_valid continues normally.
REQ-022 LOCKED: loss_cnt clears on each valid token word and increments on each valid non-token word; reaching LOSS_WORDS SHALL deassert locked, clear all counters, go to SEARCH, and keep slip.
REQ-023 slip SHALL change only on a timeout event; par_data after a slip reflects the new offset at the next capture.

Reset
REQ-024 While sys_rst_n is low: hist=0, cnt=0, par_data=0, par_valid=0, locked=0, slip=0, all counters 0, state SEARCH.
REQ-025 Reset assertion mid-operation SHALL take effect immediately (asynchronous) and discard alignment; release is synchronous to clk_5x.

Structure
REQ-026 A shared package SHALL hold the four TMDS control-token constants and the FSM state enum (SEARCH, SETTLE, LOCKED); the paired serializer reuses the tokens.
REQ-027 One sub-module, tmds_token_det (10-bit word in, is_token out), SHALL be instantiated; the bit-slip window mux, counters and FSM stay in ser_to_par.

Verification
REQ-028 Reset: hold sys_rst_n low for 10 cycles with random serial input -> par_data=0, par_valid=0, locked=0, slip=0 throughout.
REQ-029 Repeated 10'h354 stream, zero offset -> par_valid every 5 cycles; locked rises after the 8th valid word; slip=0; par_data=10'h354.
REQ-030 Same stream delayed 3 bits -> slip steps 1,2,3 at 1024-word intervals (plus 2 settle words each); then locked=1 with par_data=10'h354.
REQ-031 After lock, 4096 consecutive 10'h1F0 words -> locked drops on the 4096th; slip retained; re-locks after 8 tokens.
REQ-032 Token-free stream for 10 timeouts -> slip sequence 1..9 then 0; locked stays 0.
REQ-033 sys_rst_n pulsed low mid-SEARCH at slip=5 -> slip=0, counters cleared; the first par_valid occurs 5 cycles after release.
